tdc_sequencer: RTL
==================

// Module: tdc_sequencer
// PURPOSE
//  Run controller for tdc_core: arms it N times per run, supervises each shot with a
//  timeout, aborts a hung core, and accumulates sum/min/max/counts. A single result
//  record goes to the host/UART side via a valid/ready handshake. Sits between the
//  host command decoder and tdc_core.
// PARAMETERS
//  CNT_W      8   width of shot count and the ok/timeout counters
//  TMO_W      28  width of the per-shot timeout (100 MHz cycles)
//  MEAS_W     40  tdc_core measurement width
//  SUM_W      48  accumulator width (MEAS_W+CNT_W; no overflow possible)
//  ABORT_LEN  2   cycles tdc_abort is held high
// PORTS
//  clk          in   1       100 MHz system clock
//  rst          in   1       synchronous reset, active-high
//  start        in   1       pulse: begin a run (ignored unless IDLE)
//  stop         in   1       pulse: end the run early (ignored in IDLE/REPORT)
//  cfg_shots    in   CNT_W   shots per run, sampled on start; 0 is treated as 1
//  cfg_timeout  in   TMO_W   per-shot timeout, sampled on start; 0 disables timeout
//  tdc_arm      out  1       one-cycle arm pulse to tdc_core
//  tdc_abort    out  1       high ABORT_LEN cycles; top ORs it into the tdc_core reset
//  meas_in      in   MEAS_W  tdc_core measurement
//  meas_valid   in   1       tdc_core one-cycle valid
//  busy         out  1       high in every state except IDLE
//  res_valid    out  1       result record valid; held until accepted
//  res_ready    in   1       consumer accepts when res_valid&&res_ready
//  res_sum      out  SUM_W   sum of accepted measurements
//  res_min      out  MEAS_W  minimum (all ones if res_ok==0)
//  res_max      out  MEAS_W  maximum (0 if res_ok==0)
//  res_ok       out  CNT_W   shots that produced a measurement
//  res_tmo      out  CNT_W   shots that timed out
//  res_stopped  out  1       run ended by stop
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except res_min = all ones; counters/timer cleared.
//   rst overrides everything, including a pending res_valid (record is lost).
//  States: IDLE, ARM, WAIT, ABORT, REPORT.
//  IDLE: on start, latch cfg, clear sum/ok/tmo/attempt counters, min=~0, max=0, -> ARM.
//  ARM (1 cycle): tdc_arm=1, timer=0 -> WAIT.
//  WAIT: timer increments every cycle (saturates).
//   - meas_valid: on the next edge sum+=meas_in, min/max update, ok++, attempts++.
//     Then -> REPORT if attempts==shots, else -> ARM (gap of 0 idle cycles).
//   - else if cfg_timeout!=0 and timer==cfg_timeout-1: tmo++, attempts++ -> ABORT.
//   - meas_valid in the timeout cycle: the measurement wins, no timeout counted.
//   - stop (without meas_valid): res_stopped=1 -> ABORT; no attempt counted.
//     stop with meas_valid: the measurement is accumulated, then -> ABORT flagged stopped.
//  ABORT: tdc_abort=1 for exactly ABORT_LEN cycles. Then -> REPORT if stopped or
//   attempts==shots, else -> ARM.
//  REPORT: res_valid=1, res_* stable; on res_valid&&res_ready -> IDLE (res_valid low
//   the next cycle). start is ignored until IDLE; stop is ignored here.
//  meas_valid outside WAIT is ignored (no accumulation).
//  Shot latency: arm on cycle t -> earliest accumulation at t+1 after meas_valid.
//  min/max compare unsigned on the full MEAS_W. Counters never wrap (attempts<=shots).
// TESTING
//  T1 shots=4, tmo=1000, meas_valid with 100,300,200,50 -> res_sum=650, min=50,
//     max=300, ok=4, tmo=0, 4 arm pulses.
//  T2 shots=3, tmo=20, second shot never answers -> tdc_abort high 2 cycles exactly 20
//     cycles after its arm; result ok=2, tmo=1.
//  T3 meas_valid in the same cycle as timer==tmo-1 -> counted ok, no tdc_abort.
//  T4 shots=10, stop after 2 measurements -> abort pulse, res_stopped=1, ok=2, tmo=0.
//  T5 res_ready held low 50 cycles -> res_valid and res_* stable; start during this time is
//     ignored; after the handshake, busy=0.
//  T6 shots=0 -> exactly one shot; rst asserted in WAIT -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/tdc_sequencer_if.sv
// Result-record channel between tdc_sequencer and the host/UART side.
//   master : producer (tdc_sequencer) drives res_valid and the record fields
//   slave  : consumer drives res_ready; a record transfers on res_valid && res_ready
// The record fields hold steady for as long as res_valid is high.
interface tdc_sequencer_if #(
    parameter int CNT_W  = 8,
    parameter int MEAS_W = 40,
    parameter int SUM_W  = 48
);
    logic              res_valid;
    logic              res_ready;
    logic [SUM_W-1:0]  res_sum;
    logic [MEAS_W-1:0] res_min;
    logic [MEAS_W-1:0] res_max;
    logic [CNT_W-1:0]  res_ok;
    logic [CNT_W-1:0]  res_tmo;
    logic              res_stopped;

    modport master (
        output res_valid, res_sum, res_min, res_max, res_ok, res_tmo, res_stopped,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_sum, res_min, res_max, res_ok, res_tmo, res_stopped,
        output res_ready
    );
endinterface

// File: rtl/tdc_sequencer.sv
// tdc_sequencer: run controller for tdc_core.
// Arms the core once per shot, supervises each shot with a timeout, aborts a
// hung core and accumulates sum/min/max/ok/timeout counts. One result record
// per run is offered on the res channel.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, stop     run control pulses from the host command decoder
//   cfg_shots       shots per run (0 behaves as 1), sampled on start
//   cfg_timeout     per-shot timeout in clk cycles (0 = none), sampled on start
//   tdc_arm         one-cycle arm pulse to tdc_core
//   tdc_abort       ABORT_LEN-cycle abort pulse (ORed into the core reset upstream)
//   meas_in/valid   measurement from tdc_core
//   busy            high whenever not IDLE
//   res             result record channel (master side)
module tdc_sequencer #(
    parameter int CNT_W     = 8,
    parameter int TMO_W     = 28,
    parameter int MEAS_W    = 40,
    parameter int SUM_W     = 48,
    parameter int ABORT_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_shots,
    input  logic [TMO_W-1:0]  cfg_timeout,
    output logic              tdc_arm,
    output logic              tdc_abort,
    input  logic [MEAS_W-1:0] meas_in,
    input  logic              meas_valid,
    output logic              busy,
    tdc_sequencer_if.master   res
);
    localparam int AC_W = (ABORT_LEN > 1) ? $clog2(ABORT_LEN) : 1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT, ABORT, REPORT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  shots_q, shots_d;
    logic [TMO_W-1:0]  tmo_cfg_q, tmo_cfg_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [MEAS_W-1:0] min_q, min_d;
    logic [MEAS_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  ok_q, ok_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  att_q, att_d;
    logic              stopped_q, stopped_d;
    logic [AC_W-1:0]   abort_cnt_q, abort_cnt_d;

    logic [TMO_W-1:0]  timer_inc;
    logic              last_shot;
    logic              timed_out;

    // The timer is cleared on every entry into ARM, so it reads 0 in the arm
    // cycle and counts cycles since the arm pulse. The timeout therefore fires
    // (abort begins) exactly cfg_timeout cycles after the arm pulse.
    assign timer_inc = (timer_q == {TMO_W{1'b1}}) ? timer_q : timer_q + TMO_W'(1);
    assign last_shot = (att_q + CNT_W'(1)) == shots_q;
    // '>=' rather than '==' so cfg_timeout==1 still fires (timer is already 1 in WAIT).
    assign timed_out = (tmo_cfg_q != '0) && (timer_q >= tmo_cfg_q - TMO_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shots_q     <= '0;
            tmo_cfg_q   <= '0;
            timer_q     <= '0;
            sum_q       <= '0;
            min_q       <= '1;
            max_q       <= '0;
            ok_q        <= '0;
            tmo_q       <= '0;
            att_q       <= '0;
            stopped_q   <= 1'b0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shots_q     <= shots_d;
            tmo_cfg_q   <= tmo_cfg_d;
            timer_q     <= timer_d;
            sum_q       <= sum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            ok_q        <= ok_d;
            tmo_q       <= tmo_d;
            att_q       <= att_d;
            stopped_q   <= stopped_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shots_d     = shots_q;
        tmo_cfg_d   = tmo_cfg_q;
        timer_d     = timer_q;
        sum_d       = sum_q;
        min_d       = min_q;
        max_d       = max_q;
        ok_d        = ok_q;
        tmo_d       = tmo_q;
        att_d       = att_q;
        stopped_d   = stopped_q;
        abort_cnt_d = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shots_d   = (cfg_shots == '0) ? CNT_W'(1) : cfg_shots;
                    tmo_cfg_d = cfg_timeout;
                    sum_d     = '0;
                    min_d     = '1;
                    max_d     = '0;
                    ok_d      = '0;
                    tmo_d     = '0;
                    att_d     = '0;
                    stopped_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                timer_d = timer_inc;
                if (stop) begin
                    // The core has just been armed, so it must be aborted.
                    stopped_d = 1'b1;
                    state_d   = ABORT;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_inc;
                if (meas_valid) begin
                    // A measurement beats both stop and a coincident timeout.
                    sum_d = sum_q + SUM_W'(meas_in);
                    if (meas_in < min_q) min_d = meas_in;
                    if (meas_in > max_q) max_d = meas_in;
                    ok_d  = ok_q + CNT_W'(1);
                    att_d = att_q + CNT_W'(1);
                    if (stop) begin
                        stopped_d = 1'b1;
                        state_d   = ABORT;
                    end else if (last_shot) begin
                        state_d = REPORT;
                    end else begin
                        timer_d = '0;
                        state_d = ARM;
                    end
                end else if (stop) begin
                    stopped_d = 1'b1;
                    state_d   = ABORT;
                end else if (timed_out) begin
                    tmo_d   = tmo_q + CNT_W'(1);
                    att_d   = att_q + CNT_W'(1);
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (stop) stopped_d = 1'b1;
                if (abort_cnt_q == AC_W'(ABORT_LEN - 1)) begin
                    if (stopped_q || stop || (att_q == shots_q)) begin
                        state_d = REPORT;
                    end else begin
                        timer_d = '0;
                        state_d = ARM;
                    end
                end else begin
                    abort_cnt_d = abort_cnt_q + AC_W'(1);
                end
            end
            REPORT: begin
                if (res.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tdc_arm         = (state_q == ARM);
    assign tdc_abort       = (state_q == ABORT);
    assign busy            = (state_q != IDLE);
    assign res.res_valid   = (state_q == REPORT);
    assign res.res_sum     = sum_q;
    assign res.res_min     = min_q;
    assign res.res_max     = max_q;
    assign res.res_ok      = ok_q;
    assign res.res_tmo     = tmo_q;
    assign res.res_stopped = stopped_q;
endmodule
